// File: rtl/ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_if
// Handshake bundle between the instruction decoder (master) and the control
// pipeline (slave).
//   master drives : stall_ext, flush_ex and the decoded ID-stage fields
//                   (id_valid, id_ctrl, id_rs1/2, id_use_rs1/2, id_rd,
//                    id_rf_le, id_load, id_psr_en, id_branch)
//   slave drives  : id_stall, ex/mem/wb_valid, ex/mem/wb_ctrl, wb_rd,
//                   wb_rf_le, fwd_a_sel, fwd_b_sel
// -----------------------------------------------------------------------------
interface ctrl_pipe_if #(
  parameter int CTRL_W = 24,
  parameter int RA_W   = 5
);
  logic              stall_ext;
  logic              flush_ex;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [RA_W-1:0]   id_rd;
  logic              id_rf_le;
  logic              id_load;
  logic              id_psr_en;
  logic              id_branch;

  logic              id_stall;
  logic              ex_valid;
  logic              mem_valid;
  logic              wb_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [RA_W-1:0]   wb_rd;
  logic              wb_rf_le;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;

  modport master (
    output stall_ext, flush_ex, id_valid, id_ctrl, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_rf_le, id_load, id_psr_en,
           id_branch,
    input  id_stall, ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl,
           wb_ctrl, wb_rd, wb_rf_le, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  stall_ext, flush_ex, id_valid, id_ctrl, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_rf_le, id_load, id_psr_en,
           id_branch,
    output id_stall, ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl,
           wb_ctrl, wb_rd, wb_rf_le, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
// Carries the decoded control bundle ID -> EX -> MEM -> WB and resolves data
// and condition-code hazards for the instruction sitting in ID.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every stage
//   bus    : ctrl_pipe_if.slave -- ID-stage inputs, stall_ext/flush_ex,
//            per-stage valid/ctrl, WB register-file write control,
//            id_stall and operand forwarding selects (00 RF, 01 EX,
//            10 MEM, 11 WB)
// Parameters:
//   CTRL_W : width of the opaque control bundle
//   RA_W   : register-address width
//   FWD_EN : 1 = forwarding, stall only on load-use; 0 = stall on any RAW
//            against EX or MEM (register file is write-before-read, so WB
//            never conflicts)
// -----------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int CTRL_W = 24,
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [RA_W-1:0]   rd;
    logic              rf_le;
    logic              load;
    logic              psr_en;
  } stage_t;

  stage_t ex_r;
  stage_t mem_r;
  stage_t wb_r;
  stage_t ex_nxt_s;

  logic ex_m1_s, ex_m2_s, mem_m1_s, mem_m2_s, wb_m1_s, wb_m2_s;
  logic data_haz_s;
  logic cc_haz_s;
  logic id_stall_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // A stage produces the value an ID source needs; r0 is hard-wired and
  // never matches.
  function automatic logic src_match(input stage_t s, input logic [RA_W-1:0] rs,
                                     input logic use_rs);
    return s.valid & s.rf_le & (s.rd == rs) & use_rs & (rs != {RA_W{1'b0}});
  endfunction

  // Newest producer wins. A load in EX cannot forward (its data is not back
  // yet); that case stalls instead, so it is skipped here.
  function automatic logic [1:0] fwd_code(input logic ex_m, input logic ex_load,
                                          input logic mem_m, input logic wb_m);
    if (ex_m && !ex_load) begin
      return 2'b01;
    end else if (mem_m) begin
      return 2'b10;
    end else if (wb_m) begin
      return 2'b11;
    end else begin
      return 2'b00;
    end
  endfunction

  assign ex_m1_s  = src_match(ex_r,  bus.id_rs1, bus.id_use_rs1);
  assign ex_m2_s  = src_match(ex_r,  bus.id_rs2, bus.id_use_rs2);
  assign mem_m1_s = src_match(mem_r, bus.id_rs1, bus.id_use_rs1);
  assign mem_m2_s = src_match(mem_r, bus.id_rs2, bus.id_use_rs2);
  assign wb_m1_s  = src_match(wb_r,  bus.id_rs1, bus.id_use_rs1);
  assign wb_m2_s  = src_match(wb_r,  bus.id_rs2, bus.id_use_rs2);

  // Data hazard detection for the selected forwarding mode
  always_comb begin
    data_haz_s = 1'b0;
    if (FWD_EN) begin
      data_haz_s = (ex_m1_s | ex_m2_s) & ex_r.load;
    end else begin
      data_haz_s = ex_m1_s | ex_m2_s | mem_m1_s | mem_m2_s;
    end
  end

  // Branch reading condition codes still being produced in EX
  assign cc_haz_s   = bus.id_branch & ex_r.valid & ex_r.psr_en;
  // Under an external freeze nothing moves, so there is nothing to stall for
  assign id_stall_s = bus.id_valid & (data_haz_s | cc_haz_s) & ~bus.stall_ext;

  // Operand forwarding select generation
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (FWD_EN) begin
      fwd_a_s = fwd_code(ex_m1_s, ex_r.load, mem_m1_s, wb_m1_s);
      fwd_b_s = fwd_code(ex_m2_s, ex_r.load, mem_m2_s, wb_m2_s);
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  // Next EX contents: a flush and a hazard bubble both yield an empty stage
  always_comb begin
    ex_nxt_s = '0;
    if (bus.flush_ex || id_stall_s) begin
      ex_nxt_s = '0;
    end else begin
      ex_nxt_s.valid  = bus.id_valid;
      ex_nxt_s.ctrl   = bus.id_ctrl;
      ex_nxt_s.rd     = bus.id_rd;
      ex_nxt_s.rf_le  = bus.id_rf_le;
      ex_nxt_s.load   = bus.id_load;
      ex_nxt_s.psr_en = bus.id_psr_en;
    end
  end

  // Stage registers: advance every cycle unless frozen by stall_ext
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (!bus.stall_ext) begin
      ex_r  <= ex_nxt_s;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end else begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end
  end

  assign bus.id_stall  = id_stall_s;
  assign bus.fwd_a_sel = fwd_a_s;
  assign bus.fwd_b_sel = fwd_b_s;
  assign bus.ex_valid  = ex_r.valid;
  assign bus.mem_valid = mem_r.valid;
  assign bus.wb_valid  = wb_r.valid;
  assign bus.ex_ctrl   = ex_r.ctrl;
  assign bus.mem_ctrl  = mem_r.ctrl;
  assign bus.wb_ctrl   = wb_r.ctrl;
  // Register-file write port is only live for a real WB instruction
  assign bus.wb_rd     = wb_r.valid ? wb_r.rd : {RA_W{1'b0}};
  assign bus.wb_rf_le  = wb_r.valid & wb_r.rf_le;

endmodule

// File: tb/tb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe
// Drives one ID instruction stream into two ctrl_pipe instances (FWD_EN=1 and
// FWD_EN=0) and compares both against a per-instance reference model of the
// pipeline kept as an array of in-flight instructions.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe;
  localparam int CW = 24;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          stall_ext, flush_ex, id_valid;
  logic [CW-1:0] id_ctrl;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_rf_le, id_load, id_psr_en, id_branch;

  ctrl_pipe_if #(.CTRL_W(CW), .RA_W(RW)) bus0 ();
  ctrl_pipe_if #(.CTRL_W(CW), .RA_W(RW)) bus1 ();

  assign bus0.stall_ext = stall_ext;   assign bus1.stall_ext = stall_ext;
  assign bus0.flush_ex = flush_ex;     assign bus1.flush_ex = flush_ex;
  assign bus0.id_valid = id_valid;     assign bus1.id_valid = id_valid;
  assign bus0.id_ctrl = id_ctrl;       assign bus1.id_ctrl = id_ctrl;
  assign bus0.id_rs1 = id_rs1;         assign bus1.id_rs1 = id_rs1;
  assign bus0.id_rs2 = id_rs2;         assign bus1.id_rs2 = id_rs2;
  assign bus0.id_use_rs1 = id_use_rs1; assign bus1.id_use_rs1 = id_use_rs1;
  assign bus0.id_use_rs2 = id_use_rs2; assign bus1.id_use_rs2 = id_use_rs2;
  assign bus0.id_rd = id_rd;           assign bus1.id_rd = id_rd;
  assign bus0.id_rf_le = id_rf_le;     assign bus1.id_rf_le = id_rf_le;
  assign bus0.id_load = id_load;       assign bus1.id_load = id_load;
  assign bus0.id_psr_en = id_psr_en;   assign bus1.id_psr_en = id_psr_en;
  assign bus0.id_branch = id_branch;   assign bus1.id_branch = id_branch;

  ctrl_pipe #(.CTRL_W(CW), .RA_W(RW), .FWD_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ctrl_pipe #(.CTRL_W(CW), .RA_W(RW), .FWD_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          v;
    logic [CW-1:0] ctrl;
    logic [RW-1:0] rd;
    logic          rf;
    logic          ld;
    logic          psr;
  } ins_t;

  // pipe[m][0]=EX, [1]=MEM, [2]=WB ; m=0 forwarding, m=1 no forwarding
  ins_t pipe [2][3];

  function automatic void model_clear();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 3; k++) pipe[m][k] = '0;
  endfunction

  function automatic logic m_match(ins_t p, logic [RW-1:0] rs, logic u);
    return p.v && p.rf && (p.rd == rs) && u && (rs != 5'd0);
  endfunction

  function automatic logic m_stall(int m);
    logic haz = 1'b0;
    logic cc;
    for (int k = 0; k < 3; k++) begin
      if (m_match(pipe[m][k], id_rs1, id_use_rs1) || m_match(pipe[m][k], id_rs2, id_use_rs2)) begin
        if (m == 0) begin
          if (k == 0 && pipe[m][k].ld) haz = 1'b1;
        end else begin
          if (k < 2) haz = 1'b1;
        end
      end
    end
    cc = id_branch && pipe[m][0].v && pipe[m][0].psr;
    return id_valid && (haz || cc) && !stall_ext;
  endfunction

  function automatic logic [1:0] m_fwd(int m, logic [RW-1:0] rs, logic u);
    if (m != 0) return 2'b00;
    for (int k = 0; k < 3; k++) begin
      if (m_match(pipe[m][k], rs, u) && !(k == 0 && pipe[m][k].ld)) return 2'(k + 1);
    end
    return 2'b00;
  endfunction

  function automatic void m_advance(int m, logic st);
    if (!stall_ext) begin
      pipe[m][2] = pipe[m][1];
      pipe[m][1] = pipe[m][0];
      if (flush_ex || st) pipe[m][0] = '0;
      else pipe[m][0] = '{id_valid, id_ctrl, id_rd, id_rf_le, id_load, id_psr_en};
    end
  endfunction

  // ---------------- check helpers ----------------
  task automatic cmp_comb(input int m, input logic st, input logic [1:0] fa, input logic [1:0] fb);
    logic es;
    es = m_stall(m);
    chk($sformatf("m%0d_id_stall", m), 32'(st), 32'(es));
    if (!es) begin
      chk($sformatf("m%0d_fwd_a", m), 32'(fa), 32'(m_fwd(m, id_rs1, id_use_rs1)));
      chk($sformatf("m%0d_fwd_b", m), 32'(fb), 32'(m_fwd(m, id_rs2, id_use_rs2)));
    end
  endtask

  task automatic cmp_regs(input int m, input logic ev, input logic mv, input logic wv,
                          input logic [CW-1:0] ec, input logic [CW-1:0] mc, input logic [CW-1:0] wc,
                          input logic [RW-1:0] wrd, input logic wle);
    chk($sformatf("m%0d_ex_valid", m), 32'(ev), 32'(pipe[m][0].v));
    chk($sformatf("m%0d_mem_valid", m), 32'(mv), 32'(pipe[m][1].v));
    chk($sformatf("m%0d_wb_valid", m), 32'(wv), 32'(pipe[m][2].v));
    chk($sformatf("m%0d_ex_ctrl", m), 32'(ec), 32'(pipe[m][0].ctrl));
    chk($sformatf("m%0d_mem_ctrl", m), 32'(mc), 32'(pipe[m][1].ctrl));
    chk($sformatf("m%0d_wb_ctrl", m), 32'(wc), 32'(pipe[m][2].ctrl));
    chk($sformatf("m%0d_wb_rd", m), 32'(wrd), pipe[m][2].v ? 32'(pipe[m][2].rd) : 32'd0);
    chk($sformatf("m%0d_wb_rf_le", m), 32'(wle), 32'(pipe[m][2].v && pipe[m][2].rf));
  endtask

  task automatic check_comb();
    #1;
    cmp_comb(0, bus0.id_stall, bus0.fwd_a_sel, bus0.fwd_b_sel);
    cmp_comb(1, bus1.id_stall, bus1.fwd_a_sel, bus1.fwd_b_sel);
  endtask

  task automatic tick();
    logic s0, s1;
    s0 = m_stall(0);
    s1 = m_stall(1);
    @(posedge clk);
    m_advance(0, s0);
    m_advance(1, s1);
    #1;
    cmp_regs(0, bus0.ex_valid, bus0.mem_valid, bus0.wb_valid, bus0.ex_ctrl, bus0.mem_ctrl,
             bus0.wb_ctrl, bus0.wb_rd, bus0.wb_rf_le);
    cmp_regs(1, bus1.ex_valid, bus1.mem_valid, bus1.wb_valid, bus1.ex_ctrl, bus1.mem_ctrl,
             bus1.wb_ctrl, bus1.wb_rd, bus1.wb_rf_le);
  endtask

  task automatic set_nop();
    stall_ext = 1'b0; flush_ex = 1'b0; id_valid = 1'b0; id_ctrl = 24'h0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = 5'd0; id_rf_le = 1'b0; id_load = 1'b0; id_psr_en = 1'b0; id_branch = 1'b0;
  endtask

  task automatic set_ins(input logic [CW-1:0] c, input logic [RW-1:0] rd, input logic rf,
                         input logic [RW-1:0] rs1, input logic u1,
                         input logic [RW-1:0] rs2, input logic u2,
                         input logic ld, input logic psr, input logic br);
    set_nop();
    id_valid = 1'b1; id_ctrl = c; id_rd = rd; id_rf_le = rf;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_load = ld; id_psr_en = psr; id_branch = br;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_nop();
      check_comb();
      tick();
    end
  endtask

  initial begin
    set_nop();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    // Reset state
    check_comb();
    cmp_regs(0, bus0.ex_valid, bus0.mem_valid, bus0.wb_valid, bus0.ex_ctrl, bus0.mem_ctrl,
             bus0.wb_ctrl, bus0.wb_rd, bus0.wb_rf_le);
    cmp_regs(1, bus1.ex_valid, bus1.mem_valid, bus1.wb_valid, bus1.ex_ctrl, bus1.mem_ctrl,
             bus1.wb_ctrl, bus1.wb_rd, bus1.wb_rf_le);
    rst_n = 1'b1;

    // add r1 = r2 + r3 flows through
    set_ins(24'h00A001, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_comb();
    tick();
    chk("add_ex_valid", 32'(bus0.ex_valid), 32'd1);
    set_nop(); check_comb(); tick();
    chk("add_mem_valid", 32'(bus0.mem_valid), 32'd1);
    set_nop(); check_comb(); tick();
    chk("add_wb_valid", 32'(bus0.wb_valid), 32'd1);
    chk("add_wb_rf_le", 32'(bus0.wb_rf_le), 32'd1);
    chk("add_wb_rd", 32'(bus0.wb_rd), 32'd1);
    nops(3);

    // Load-use with forwarding: one stall, bubble, then MEM forward
    set_ins(24'h00B004, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_comb(); tick();
    set_ins(24'h00A005, 5'd5, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check_comb();
    chk("lu_stall", 32'(bus0.id_stall), 32'd1);
    tick();
    chk("lu_bubble", 32'(bus0.ex_valid), 32'd0);
    check_comb();
    chk("lu_released", 32'(bus0.id_stall), 32'd0);
    chk("lu_fwd_mem", 32'(bus0.fwd_a_sel), 32'd2);
    tick();
    nops(3);

    // Forwarding from EX, MEM, WB in turn; r0 never forwards
    set_ins(24'h00A007, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb(); tick();
    set_ins(24'h00C001, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb(); chk("fwd_ex", 32'(bus0.fwd_a_sel), 32'd1); tick();
    check_comb(); chk("fwd_mem", 32'(bus0.fwd_a_sel), 32'd2); tick();
    check_comb(); chk("fwd_wb", 32'(bus0.fwd_a_sel), 32'd3); tick();
    nops(3);
    set_ins(24'h00A000, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb(); tick();
    set_ins(24'h00C002, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_comb(); chk("fwd_r0", 32'(bus0.fwd_a_sel), 32'd0); tick();
    nops(3);

    // No forwarding: RAW against EX costs two stall cycles
    set_ins(24'h00A007, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb(); tick();
    set_ins(24'h00C003, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb();
    chk("nf_stall_1", 32'(bus1.id_stall), 32'd1);
    chk("nf_fwd_1", 32'(bus1.fwd_a_sel), 32'd0);
    tick();
    check_comb(); chk("nf_stall_2", 32'(bus1.id_stall), 32'd1); tick();
    check_comb();
    chk("nf_stall_3", 32'(bus1.id_stall), 32'd0);
    chk("nf_fwd_3", 32'(bus1.fwd_a_sel), 32'd0);
    tick();
    nops(3);

    // subcc then bne: one stall cycle
    set_ins(24'h00D008, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb(); tick();
    set_ins(24'h00E000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_comb();
    chk("cc_stall_fwd", 32'(bus0.id_stall), 32'd1);
    chk("cc_stall_nofwd", 32'(bus1.id_stall), 32'd1);
    tick();
    chk("cc_bubble", 32'(bus0.ex_valid), 32'd0);
    check_comb(); chk("cc_released", 32'(bus0.id_stall), 32'd0); tick();
    nops(3);

    // flush_ex during a CC stall still leaves a bubble in EX
    set_ins(24'h00D009, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb(); tick();
    set_ins(24'h00E001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    flush_ex = 1'b1;
    check_comb(); chk("flush_stall", 32'(bus0.id_stall), 32'd1); tick();
    chk("flush_bubble", 32'(bus0.ex_valid), 32'd0);
    chk("flush_ex_ctrl", 32'(bus0.ex_ctrl), 32'd0);
    nops(3);

    // stall_ext freezes everything and masks id_stall
    set_ins(24'h00D00A, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb(); tick();
    for (int i = 0; i < 3; i++) begin
      set_ins(24'h00E002, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      stall_ext = 1'b1;
      check_comb(); chk("ext_no_stall", 32'(bus0.id_stall), 32'd0); tick();
      chk("ext_frozen_ctrl", 32'(bus0.ex_ctrl), 32'h00D00A);
    end
    stall_ext = 1'b0;
    check_comb(); chk("ext_resume_stall", 32'(bus0.id_stall), 32'd1); tick();
    nops(3);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      set_nop();
      id_valid   = 1'($urandom_range(0, 3) != 0);
      id_ctrl    = 24'($urandom);
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      id_rd      = 5'($urandom_range(0, 3));
      id_rf_le   = 1'($urandom);
      id_load    = 1'($urandom_range(0, 2) == 0);
      id_psr_en  = 1'($urandom_range(0, 3) == 0);
      id_branch  = 1'($urandom_range(0, 3) == 0);
      stall_ext  = 1'($urandom_range(0, 7) == 0);
      flush_ex   = 1'($urandom_range(0, 7) == 0);
      check_comb();
      tick();
    end
    nops(3);

    // Reset asserted in the middle of a load-use stall
    set_ins(24'h00B00C, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_comb(); tick();
    set_ins(24'h00A00D, 5'd13, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb();
    chk("rst_pre_stall", 32'(bus0.id_stall), 32'd1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_async_ex_fwd", 32'(bus0.ex_valid), 32'd0);
    chk("rst_async_ex_nofwd", 32'(bus1.ex_valid), 32'd0);
    chk("rst_async_stall", 32'(bus0.id_stall), 32'd0);
    #1;
    rst_n = 1'b1;
    check_comb();
    tick();
    nops(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
